// File: rtl/pq_pkg.sv
// Shared types for the shift-register priority queue and its release consumer.
package pq_pkg;

    localparam int KW = 4;
    localparam int VW = 4;

    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] val;
    } kv_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/pq_obuf.sv
// Two-entry oldest-first output FIFO that decouples queue pops from the consumer.
module pq_obuf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic [W-1:0] din,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    // Handshake: an entry moves on every cycle where valid && ready at the clock edge;
    // while valid && !ready the head register is untouched, so dout holds stable.
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         rd;

    assign valid = (count != 2'd0);
    assign rd    = valid && ready;
    assign dout  = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({wr, rd})
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    // A write into a full buffer is dropped; the caller never issues one.
                    if (count != 2'd2) begin
                        if (count == 2'd0) head <= din;
                        else               tail <= din;
                        count <= count + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pq_release.sv
// Event-scheduler consumer: pops the priority-queue head once its key (release time)
// is due against a local time counter and streams released entries out.
module pq_release
    import pq_pkg::*;
#(
    parameter int KW = pq_pkg::KW,
    parameter int VW = pq_pkg::VW,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick,
    input  logic [KW+VW-1:0] pq_kvo,
    input  logic             pq_empty,
    output logic             pq_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KW-1:0]    out_key,
    output logic [VW-1:0]    out_val,
    output logic [KW-1:0]    now,
    output logic [CW-1:0]    rel_cnt,
    output logic [1:0]       buf_cnt,
    output state_t           fsm_state
);

    state_t           state;
    state_t           state_nxt;
    logic             due;
    logic [KW+VW-1:0] buf_dout;

    // Plain unsigned compare: after now wraps, larger keys simply wait for now to catch up.
    assign due = !pq_empty && (pq_kvo[KW+VW-1:VW] <= now);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en && due && (buf_cnt < 2'd2)) state_nxt = POP;
            POP:     state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only one pop is ever in flight, so checking buf_cnt in IDLE guarantees a free slot.
    assign pq_pop    = (state == POP);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now     <= '0;
            rel_cnt <= '0;
        end else begin
            if (tick) now <= now + 1'b1;
            if (out_valid && out_ready) rel_cnt <= rel_cnt + 1'b1;
        end
    end

    pq_obuf #(.W(KW + VW)) u_obuf (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (pq_pop),
        .din   (pq_kvo),
        .valid (out_valid),
        .ready (out_ready),
        .dout  (buf_dout),
        .count (buf_cnt)
    );

    assign out_key = buf_dout[KW+VW-1:VW];
    assign out_val = buf_dout[VW-1:0];

endmodule

// File: doc/pq_release.md
Name: pq_release

Overview:
- Downstream consumer of the shift-register priority queue (sr_pq). Treats the queue as an event scheduler: key = release time, value = payload.
- Keeps a local time counter. Pops the queue head once its key is due.
- Delivers each released entry on a valid/ready stream through a 2-entry output buffer.

Parameters:
KW, 4, key (timestamp) width in bits; matches sr_pq KW
VW, 4, value width in bits; matches sr_pq VW
CW, 16, width of the released-entry counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  release enable; 0 freezes new pops (time still advances)
tick  input  1  advance time counter by 1 this cycle
pq_kvo  input  KW+VW  queue head {key,val} from sr_pq kvo
pq_empty  input  1  sr_pq empty flag
pq_pop  output  1  pop strobe to sr_pq, one cycle wide
out_valid  output  1  released entry available
out_ready  input  1  consumer accepts entry
out_key  output  KW  released key
out_val  output  VW  released value
now  output  KW  current time counter
rel_cnt  output  CW  number of entries accepted by consumer since reset
buf_cnt  output  2  output buffer occupancy, 0..2

Behaviour:
- Reset (async, rst_n=0): now=0, rel_cnt=0, buf_cnt=0, out_valid=0, pq_pop=0, out_key/out_val=0, FSM=IDLE. Reset mid-operation abandons any in-flight pop.
- Time counter:
  - now increments by 1 on each clk edge with tick=1.
  - Modular; wraps from 2^KW-1 to 0.
  - Due test uses the registered now, before that cycle's increment.
- Due condition: due = !pq_empty && (pq_kvo key <= now), unsigned compare. No wrap-aware compare; after wrap, larger keys wait until now reaches them.
- FSM states: IDLE, POP, SETTLE.
  - IDLE -> POP: when en && due && buf_cnt<2. Otherwise stay in IDLE.
  - POP: pq_pop=1 for exactly this cycle. pq_kvo is written into the output buffer at the end of the cycle. Always -> SETTLE.
  - SETTLE: pq_pop=0, one cycle for sr_pq head/empty to update. Always -> IDLE.
  - Throughput: at most one pop per 3 cycles. Only one pop in flight, so the buf_cnt<2 check in IDLE guarantees space.
- pq_pop is registered (driven from the state); never asserted when pq_empty was 1 at the IDLE decision.
- Output buffer: 2-entry FIFO, oldest-first.
  - out_valid = (buf_cnt != 0); out_key/out_val show the oldest entry.
  - Output fields hold stable while out_valid && !out_ready.
  - Write (POP cycle) and read (out_valid && out_ready) in the same cycle: occupancy unchanged, ordering preserved.
  - With buf_cnt=0, a write makes out_valid=1 the following cycle (no bypass).
- rel_cnt increments on each out_valid && out_ready; wraps modulo 2^CW.
- en=0: no transition IDLE->POP. A POP/SETTLE sequence already in progress completes. Buffer keeps draining.
- tick during POP/SETTLE: now advances normally; no effect on the in-flight pop.

Decomposition:
- Package pq_pkg: KW/VW defaults, typedef kv_t packed {key,val}, FSM enum state_t {IDLE,POP,SETTLE}. sr_pq_tb and sr_pq share it.
- One sub-module: pq_obuf, a 2-entry valid/ready FIFO of kv_t with count output. FSM, time counter and rel_cnt stay in pq_release.

Test Plan:
1. Reset with pq_empty=1, ticks running -> pq_pop never asserted, out_valid=0, now counts 0,1,2,...
2. Queue head {key=3,val=3}, en=1, tick each cycle from now=0:
   - no pop while now<3;
   - pq_pop exactly one cycle after IDLE sees now=3;
   - out_key=3, out_val=3 valid the cycle after POP.
3. sr_pq loaded with keys 4,5,6, now held at 7 (tick=0), out_ready=1:
   - three pops spaced 3 cycles apart;
   - outputs in order 4,5,6;
   - rel_cnt=3; pq_empty then blocks further pops.
4. out_ready=0, four due entries:
   - exactly two pops, buf_cnt=2, then pq_pop stays 0;
   - after out_ready=1 for one cycle: buf_cnt drops, one more pop, order preserved.
5. en dropped in the same cycle IDLE would transition -> no pop; pop resumes the first IDLE cycle with en=1.
6. rst_n asserted during SETTLE with buf_cnt=1 -> outputs immediately zero, FSM IDLE, rel_cnt=0. After release, the next due head is popped normally.
